// File: rtl/fuzzy_seq_pkg.sv
// fuzzy_seq_pkg: shared state encoding, counter widths and ativo group slices for fuzzy_seq_controller.
package fuzzy_seq_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    FUZZ    = 3'd2,
    INFER   = 3'd3,
    REDUCE  = 3'd4,
    DEFUZZ  = 3'd5,
    DONE    = 3'd6
  } state_t;
  localparam int CNT_INFER_W = 4;
  localparam int CNT_RED_W = 8;
  localparam int ATV_W = 6;
  localparam int ATV_HI_MSB = 5;
  localparam int ATV_HI_LSB = 3;
  localparam int ATV_LO_MSB = 2;
  localparam int ATV_LO_LSB = 0;
endpackage

// File: rtl/fuzzy_seq_cnt.sv
// fuzzy_seq_cnt: loadable up/down counter whose terminal flag compares the count against a limit.
module fuzzy_seq_cnt #(
  parameter int W = 4,
  parameter bit UP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] lim,
  output logic [W-1:0] q,
  output logic         term
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (load) q <= load_val;
    else if (en) q <= UP ? q + W'(1) : q - W'(1);
  assign term = q == lim;
endmodule

// File: rtl/fuzzy_seq_controller.sv
// fuzzy_seq_controller: sequences fuzzifier -> inference -> type reducer -> defuzzifier with valid/ready ends.
// Optional FUZZY_SEQ_RULE_SKIP_EN adds ativo/no_rule and bypasses inference when no rule can fire.
module fuzzy_seq_controller
  import fuzzy_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int INFER_CYCLES = 2,
  parameter int REDUCE_MAX = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              soft_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_01,
  input  logic [DATA_W-1:0] in_02,
  output logic [DATA_W-1:0] smp_01,
  output logic [DATA_W-1:0] smp_02,
  output logic              en_fuzz,
  output logic              en_infer,
  output logic              en_reduce,
  input  logic              reduce_done,
  output logic              en_defuzz,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout
`ifdef FUZZY_SEQ_RULE_SKIP_EN
  ,
  input  logic [ATV_W-1:0]  ativo,
  output logic              no_rule
`endif
);
  localparam logic [CNT_INFER_W-1:0] INF_LOAD = CNT_INFER_W'(INFER_CYCLES - 1);
  localparam logic [CNT_RED_W-1:0] RED_LIM = CNT_RED_W'(REDUCE_MAX);
  state_t state, nxt;
  logic [CNT_INFER_W-1:0] inf_q;
  logic [CNT_RED_W-1:0] red_q;
  logic inf_term, red_term, accept, rule_empty, skip;
  assign accept = state == IDLE && in_valid && !soft_clear;
`ifdef FUZZY_SEQ_RULE_SKIP_EN
  assign rule_empty = ativo[ATV_HI_MSB:ATV_HI_LSB] == '0 || ativo[ATV_LO_MSB:ATV_LO_LSB] == '0;
`else
  assign rule_empty = 1'b0;
`endif
  // the INFER counter still holds its load value only in the first INFER cycle
  assign skip = state == INFER && inf_q == INF_LOAD && rule_empty;
  fuzzy_seq_cnt #(.W(CNT_INFER_W), .UP(1'b0)) u_inf_cnt (
    .clk(clk),
    .rst(RESET),
    .load(state != INFER),
    .en(1'b1),
    .load_val(INF_LOAD),
    .lim('0),
    .q(inf_q),
    .term(inf_term)
  );
  // red_q equals the 1-based index of the current REDUCE cycle
  fuzzy_seq_cnt #(.W(CNT_RED_W), .UP(1'b1)) u_red_cnt (
    .clk(clk),
    .rst(RESET),
    .load(state != REDUCE),
    .en(1'b1),
    .load_val(CNT_RED_W'(1)),
    .lim(RED_LIM),
    .q(red_q),
    .term(red_term)
  );
  always_ff @(posedge clk or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = in_valid ? CAPTURE : IDLE;
      CAPTURE: nxt = FUZZ;
      FUZZ:    nxt = INFER;
      INFER:   nxt = skip ? DEFUZZ : inf_term ? REDUCE : INFER;
      REDUCE:  nxt = reduce_done || red_term ? DEFUZZ : REDUCE;
      DEFUZZ:  nxt = DONE;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    if (soft_clear) nxt = IDLE;
    in_ready = state == IDLE && !RESET;
    en_fuzz = state == CAPTURE || state == FUZZ;
    en_infer = state == INFER && !skip;
    en_reduce = state == REDUCE;
    en_defuzz = state == DEFUZZ;
    out_valid = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge RESET)
    if (RESET) begin
      smp_01 <= '0;
      smp_02 <= '0;
      timeout <= 1'b0;
    end else if (accept) begin
      smp_01 <= in_01;
      smp_02 <= in_02;
      timeout <= 1'b0;
    end else if (state == REDUCE && red_term && !reduce_done && !soft_clear) begin
      timeout <= 1'b1;
    end
`ifdef FUZZY_SEQ_RULE_SKIP_EN
  logic no_rule_q;
  always_ff @(posedge clk or posedge RESET)
    if (RESET) no_rule_q <= 1'b0;
    else if (accept) no_rule_q <= 1'b0;
    else if (skip && !soft_clear) no_rule_q <= 1'b1;
  assign no_rule = state == DONE && no_rule_q;
`endif
endmodule

// File: doc/fuzzy_seq_controller.md
Name: fuzzy_seq_controller

Overview:
- Sequencer for the interval type-2 fuzzy processing chain: fuzzifier block, then rule inference, type reducer, then defuzzifier.
- Accepts one input-sample pair per valid/ready handshake and holds it stable on the fuzzifier inputs.
- Generates the stage enable strobes, including the shared register enable of the fuzzifier block. It waits on the iterative type reducer and presents completion through an output valid/ready handshake.
- Sits between the sample source (ADC/host interface) and the fuzzy datapath. It is the only driver of that datapath's register enables.

Parameters:
- DATA_W, 8, width of each input sample.
- INFER_CYCLES, 2, cycles en_infer is held high (range 1..15).
- REDUCE_MAX, 16, maximum REDUCE cycles before timeout (range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- soft_clear  in  1  synchronous abort to IDLE
- in_valid  in  1  sample pair valid
- in_ready  out  1  controller can accept a sample pair
- in_01  in  DATA_W  sample for input 1
- in_02  in  DATA_W  sample for input 2
- smp_01  out  DATA_W  held sample to fuzzifier Input_01
- smp_02  out  DATA_W  held sample to fuzzifier Input_02
- en_fuzz  out  1  fuzzifier EN_SCLK
- en_infer  out  1  inference stage enable
- en_reduce  out  1  type-reducer iterate enable
- reduce_done  in  1  type reducer converged, sampled only in REDUCE
- en_defuzz  out  1  defuzzifier register enable
- out_valid  out  1  result valid at defuzzifier output
- out_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE
- timeout  out  1  sticky: reducer hit REDUCE_MAX

Behaviour:
- Reset (async, RESET=1):
  - State is IDLE.
  - smp_01 = smp_02 = 0; timeout = 0.
  - All enables, out_valid and busy are 0.
  - in_ready = 1 after RESET deasserts.
- States: IDLE, CAPTURE, FUZZ, INFER, REDUCE, DEFUZZ, DONE.
- Outputs are registered/Moore; each enable is high only in its own state.
- IDLE:
  - in_ready = 1.
  - On in_valid&in_ready, latch in_01/in_02 into smp_01/smp_02 and go to CAPTURE.
  - smp_01/smp_02 change only on an accept.
- CAPTURE: en_fuzz = 1 for one cycle; the fuzzifier input registers load. Next state FUZZ.
- FUZZ: en_fuzz = 1 for one cycle; the fuzzifier output registers load the membership values. Next state INFER.
- INFER:
  - en_infer = 1 for exactly INFER_CYCLES cycles, counted by a 4-bit down-counter loaded on entry.
  - Then go to REDUCE.
- REDUCE:
  - en_reduce = 1 while in this state; an 8-bit iteration counter increments each cycle.
  - If reduce_done = 1, go to DEFUZZ.
  - Else, if the counter has reached REDUCE_MAX, set timeout and go to DEFUZZ.
  - If reduce_done and the limit coincide, reduce_done wins and timeout is not set.
- DEFUZZ: en_defuzz = 1 for one cycle. Next state DONE.
- DONE:
  - out_valid = 1, held until out_ready = 1, then go to IDLE.
  - No in_ready bypass: a new sample is accepted at the earliest in the cycle after DONE.
- Latency:
  - Accept edge at T. out_valid is first high in cycle T+5+INFER_CYCLES+(r-1), where r is the number of REDUCE cycles (r ≥ 1).
  - Example: INFER_CYCLES=2, r=1 gives out_valid at T+7.
- soft_clear:
  - From any state, the next state is IDLE and all enables and out_valid drop the next cycle.
  - smp_01/smp_02 and timeout are retained.
  - soft_clear has priority over in_valid in IDLE: no accept that cycle.
- timeout:
  - Clears only on RESET, or on a new accept in IDLE.
- RESET asserted mid-operation:
  - All state, counters and outputs return to reset values immediately.
  - No partial strobe is completed.

Optional Feature:
- Macro: FUZZY_SEQ_RULE_SKIP_EN.
- With the macro defined:
  - An extra port ativo, 6 bits in, carries the fuzzifier's registered active-set flags.
  - In INFER's first cycle, if ativo[5:3]==0 or ativo[2:0]==0, no rule can fire.
  - In that case the controller skips to DEFUZZ with en_infer and en_reduce never asserted, and raises a DONE-cycle flag no_rule (extra 1-bit output, valid with out_valid).
- Without the macro: the ativo and no_rule ports are absent and all samples take the full path.

Decomposition:
- Package fuzzy_seq_pkg:
  - state enum type (3-bit encoding, IDLE=0);
  - localparams CNT_INFER_W=4 and CNT_RED_W=8;
  - the ativo group slice constants.
- One natural sub-module, fuzzy_seq_cnt: a loadable down/up counter with terminal flag, instanced for INFER and REDUCE.
- The FSM stays in the top.

Test Plan:
- Basic transaction (INFER_CYCLES=2): reset, accept in_01=8'd100, in_02=8'd200 at edge T, reduce_done=1 in the first REDUCE cycle.
  - smp = 100/200; en_fuzz high at T+1 and T+2; en_infer at T+3..T+4; en_reduce at T+5; en_defuzz at T+6; out_valid at T+7; timeout=0.
- Backpressure: out_ready=0 for 5 cycles.
  - out_valid held; in_ready=0 throughout; in_valid pulses are ignored and smp is unchanged; IDLE is reached one cycle after out_ready=1.
- Reducer timeout (REDUCE_MAX=16): reduce_done is never asserted.
  - en_reduce high for exactly 16 cycles; timeout=1 and stays 1 through DONE; it clears on the next accept.
- Coincident done and limit: reduce_done=1 on the 16th REDUCE cycle.
  - Goes to DEFUZZ with timeout=0.
- Abort: soft_clear in INFER cycle 1.
  - Next cycle: IDLE, en_infer=0, busy=0, smp retained.
  - Also assert RESET mid-REDUCE: all outputs are 0 immediately, asynchronously.
- FUZZY_SEQ_RULE_SKIP_EN, ativo=6'b000_101:
  - en_infer and en_reduce never assert; en_defuzz fires the cycle after INFER entry; no_rule=1 with out_valid.
